// File: rtl/wsn_mem_pkg.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Package : wsn_mem_pkg
// Brief   : Shared memory geometry, client FSM states and last-op encoding.
// Rev     : 1.0 - initial release
//==============================================================================
package wsn_mem_pkg;

    localparam int MEM_DEPTH  = 256;
    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_RD_REQ = 2'd2,
        ST_RD_CAP = 2'd3
    } mem_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

endpackage
`default_nettype wire

// File: rtl/sample_buffer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module : sample_buffer_ctrl
// Brief  : Circular sample FIFO controller sequencing a single-port memory.
// Rev    : 1.0 - initial release
//==============================================================================
module sample_buffer_ctrl
    import wsn_mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic              mem_data_ready
);

    localparam logic [ADDR_W:0]   c_FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    mem_op_e           r_last_op;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_valid;
    logic              r_run;

    logic              w_full;
    logic              w_empty;
    logic              w_rd_go;
    logic              w_s_ready;
    logic              w_wr_go;
    logic              w_rd_done;
    logic              w_mem_write;
    logic              w_mem_read;
    logic              w_bus_drive;
    logic [ADDR_W-1:0] w_mem_addr;

    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_rd_go   = !w_empty && !r_m_valid;
    // r_run keeps the input closed while reset is held and for the release cycle
    assign w_s_ready = r_run && (r_state == ST_IDLE) && !w_full && !clear
                       && (!w_rd_go || (r_last_op == OP_READ));
    assign w_wr_go   = w_s_ready && s_valid;
    assign w_rd_done = (r_state == ST_RD_CAP) && mem_data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_go) begin
                        w_state_nxt = ST_WRITE;
                    end else if (w_rd_go) begin
                        w_state_nxt = ST_RD_REQ;
                    end
                end
                ST_WRITE:  w_state_nxt = ST_IDLE;
                ST_RD_REQ: w_state_nxt = ST_RD_CAP;
                ST_RD_CAP: begin
                    if (mem_data_ready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_mem_write = 1'b0;
        w_mem_read  = 1'b0;
        w_bus_drive = 1'b0;
        w_mem_addr  = '0;
        case (r_state)
            ST_WRITE: begin
                w_mem_write = 1'b1;
                w_bus_drive = 1'b1;
                w_mem_addr  = r_wr_ptr;
            end
            ST_RD_REQ, ST_RD_CAP: begin
                w_mem_read = 1'b1;
                w_mem_addr = r_rd_ptr;
            end
            default: begin
                w_mem_write = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdata <= '0;
        end else if (w_wr_go) begin
            r_wdata <= s_data;
        end
    end

    // WRITE and RD_CAP are exclusive, so count never sees both edges at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_last_op <= OP_READ;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (clear) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            if (r_state == ST_WRITE) begin
                r_wr_ptr  <= r_wr_ptr + c_PTR_ONE;
                r_count   <= r_count + c_CNT_ONE;
                r_last_op <= OP_WRITE;
            end
            if (w_rd_done) begin
                r_m_data  <= mem_data;
                r_m_valid <= 1'b1;
                r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
                r_count   <= r_count - c_CNT_ONE;
                r_last_op <= OP_READ;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign mem_data  = w_bus_drive ? r_wdata : {DATA_W{1'bz}};
    assign mem_write = w_mem_write;
    assign mem_read  = w_mem_read;
    assign mem_addr  = w_mem_addr;
    assign s_ready   = w_s_ready;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_sample_buffer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module : tb_sample_buffer_ctrl
// Brief  : Self-checking bench with memory model and queue-based FIFO model.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_sample_buffer_ctrl;

    localparam int DEPTH = 256;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       clear   = 1'b0;
    logic       s_valid = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_ready, m_valid, full, empty, mem_write, mem_read;
    logic [7:0] m_data, mem_addr;
    logic [8:0] count;
    wire  [7:0] mem_data;
    logic       mem_data_ready;

    logic [7:0] mem_arr [256];
    int         rd_cycles = 0;
    int         lat       = 1;

    int n_cmp = 0;
    int n_err = 0;

    sample_buffer_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_data_ready (mem_data_ready)
    );

    always #5 clk = ~clk;

    // Memory model: read data returned after `lat` cycles of held mem_read
    assign mem_data_ready = mem_read && (rd_cycles >= lat);
    assign mem_data       = mem_data_ready ? mem_arr[mem_addr] : 8'bzzzz_zzzz;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_addr] <= mem_data;
        if (!mem_read || mem_data_ready) rd_cycles <= 0;
        else                             rd_cycles <= rd_cycles + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // FIFO model: accepted-not-written, written-not-captured, captured-not-consumed
    logic [7:0] pend[$];
    logic [7:0] stored[$];
    logic [7:0] outq[$];
    int         wr_idx = 0;
    int         rd_idx = 0;
    logic       prev_rd = 1'b0;
    bit         acc_last = 1'b0;
    bit         wrap_seen = 1'b0;
    bit         rec_ops = 1'b0;
    bit         ops[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete(); stored.delete(); outq.delete();
            wr_idx = 0; rd_idx = 0; prev_rd = 1'b0; acc_last = 1'b0;
        end else begin
            check_eq("count", 32'(count), 32'(stored.size()));
            check_eq("full", 32'(full), 32'(stored.size() == DEPTH));
            check_eq("empty", 32'(empty), 32'(stored.size() == 0));
            check_eq("m_valid", 32'(m_valid), 32'(outq.size() != 0));
            check_eq("strobe_overlap", 32'(mem_write && mem_read), 32'(0));
            acc_last = s_valid && s_ready;
            if (clear) begin
                pend.delete(); stored.delete(); outq.delete();
                wr_idx = 0; rd_idx = 0;
            end else begin
                if (mem_write) begin
                    check_eq("wr_addr", 32'(mem_addr), 32'(wr_idx % DEPTH));
                    check_eq("wr_pending", 32'(pend.size() != 0), 32'(1));
                    if (pend.size() != 0) begin
                        check_eq("wr_data", 32'(mem_data), 32'(pend[0]));
                        stored.push_back(pend.pop_front());
                    end
                    wr_idx++;
                    if (wr_idx >= DEPTH) wrap_seen = 1'b1;
                    if (rec_ops) ops.push_back(1'b1);
                end
                if (mem_read && !prev_rd) begin
                    check_eq("rd_nonempty", 32'(stored.size() != 0), 32'(1));
                    if (rec_ops) ops.push_back(1'b0);
                end
                if (mem_read) check_eq("rd_addr", 32'(mem_addr), 32'(rd_idx % DEPTH));
                if (mem_read && mem_data_ready && stored.size() != 0) begin
                    outq.push_back(stored.pop_front());
                    rd_idx++;
                end
                if (m_valid && m_ready && outq.size() != 0) begin
                    check_eq("m_data", 32'(m_data), 32'(outq[0]));
                    void'(outq.pop_front());
                end
                if (s_valid && s_ready) pend.push_back(s_data);
            end
            prev_rd = mem_read;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = v;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        check_eq("push_accept", 32'(ok), 32'(1));
    endtask

    task automatic drain(input string tag, input int limit);
        bit ok = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < limit; i++) begin
            cyc(1);
            if (empty && !m_valid && !mem_write && !mem_read) begin ok = 1'b1; break; end
        end
        check_eq(tag, 32'(ok), 32'(1));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit was_rd;

        // Reset values
        cyc(3);
        check_eq("rst_s_ready", 32'(s_ready), 32'(0));
        check_eq("rst_m_valid", 32'(m_valid), 32'(0));
        check_eq("rst_m_data", 32'(m_data), 32'(0));
        check_eq("rst_count", 32'(count), 32'(0));
        check_eq("rst_empty", 32'(empty), 32'(1));
        check_eq("rst_full", 32'(full), 32'(0));
        check_eq("rst_mem_write", 32'(mem_write), 32'(0));
        check_eq("rst_mem_read", 32'(mem_read), 32'(0));
        check_eq("rst_mem_addr", 32'(mem_addr), 32'(0));
        rst_n = 1'b1;
        cyc(1);

        // Single sample, cycle-exact
        lat = 1; m_ready = 1'b0;
        check_eq("single_s_ready", 32'(s_ready), 32'(1));
        s_valid = 1'b1; s_data = 8'hA5;
        cyc(1); s_valid = 1'b0;
        check_eq("single_wr", 32'(mem_write), 32'(1));
        check_eq("single_wr_addr", 32'(mem_addr), 32'(0));
        check_eq("single_wr_data", 32'(mem_data), 32'(8'hA5));
        check_eq("single_cnt0", 32'(count), 32'(0));
        cyc(1);
        check_eq("single_cnt1", 32'(count), 32'(1));
        check_eq("single_idle_rd", 32'(mem_read), 32'(0));
        cyc(1);
        check_eq("single_rdreq", 32'(mem_read), 32'(1));
        check_eq("single_mv_n3", 32'(m_valid), 32'(0));
        cyc(1);
        check_eq("single_rdcap", 32'(mem_read), 32'(1));
        check_eq("single_mv_n4", 32'(m_valid), 32'(0));
        cyc(1);
        check_eq("single_mv", 32'(m_valid), 32'(1));
        check_eq("single_mdata", 32'(m_data), 32'(8'hA5));
        check_eq("single_cnt2", 32'(count), 32'(0));
        m_ready = 1'b1;
        cyc(1);
        m_ready = 1'b0;
        check_eq("single_consumed", 32'(m_valid), 32'(0));

        // Fill to full with output stalled
        for (int i = 0; i < 256; i++) push(8'(i));
        cyc(3);
        check_eq("fill_cnt255", 32'(count), 32'(255));
        check_eq("fill_head", 32'(m_data), 32'(8'h00));
        push(8'h5A);
        cyc(2);
        check_eq("fill_cnt256", 32'(count), 32'(256));
        check_eq("fill_full", 32'(full), 32'(1));
        s_valid = 1'b1; s_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check_eq("full_s_ready", 32'(s_ready), 32'(0));
        end
        s_valid = 1'b0;
        drain("fill_drain", 4000);

        // Arbitration with ring non-empty and continuous traffic
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        cyc(2);
        rec_ops = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (acc_last) s_data = 8'($urandom);
        end
        s_valid = 1'b0;
        rec_ops = 1'b0;
        check_eq("alt_ops_n", 32'(ops.size() >= 10), 32'(1));
        for (int i = 1; i < ops.size() && i < 10; i++)
            check_eq("alt_grant", 32'(ops[i]), 32'(!ops[i-1]));
        drain("alt_drain", 200);

        // clear during RD_CAP with five entries stored
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
        cyc(6);
        check_eq("clr_setup_cnt", 32'(count), 32'(5));
        lat = 20;
        m_ready = 1'b1;
        cyc(1);
        m_ready = 1'b0;
        ok = 1'b0; was_rd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (mem_read && was_rd) begin ok = 1'b1; break; end
            was_rd = mem_read;
        end
        check_eq("clr_rdcap_seen", 32'(ok), 32'(1));
        check_eq("clr_rdcap_cnt", 32'(count), 32'(5));
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check_eq("clr_mem_read", 32'(mem_read), 32'(0));
        check_eq("clr_count", 32'(count), 32'(0));
        check_eq("clr_m_valid", 32'(m_valid), 32'(0));
        check_eq("clr_empty", 32'(empty), 32'(1));
        lat = 1;
        push(8'h3C);
        check_eq("clr_wr_addr", 32'(mem_addr), 32'(0));
        check_eq("clr_wr", 32'(mem_write), 32'(1));
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (m_valid) begin ok = 1'b1; break; end
        end
        check_eq("clr_rb_valid", 32'(ok), 32'(1));
        check_eq("clr_rb_data", 32'(m_data), 32'(8'h3C));
        drain("clr_drain", 200);

        // Asynchronous reset in the middle of a write
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'(8'h80 + i));
        cyc(4);
        s_valid = 1'b1; s_data = 8'h99;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (mem_write) begin ok = 1'b1; break; end
        end
        check_eq("arst_wr_seen", 32'(ok), 32'(1));
        check_eq("arst_pre_cnt", 32'(count), 32'(2));
        #2 rst_n = 1'b0;
        #1;
        s_valid = 1'b0;
        check_eq("arst_mem_write", 32'(mem_write), 32'(0));
        check_eq("arst_mem_read", 32'(mem_read), 32'(0));
        check_eq("arst_mem_addr", 32'(mem_addr), 32'(0));
        check_eq("arst_count", 32'(count), 32'(0));
        check_eq("arst_m_valid", 32'(m_valid), 32'(0));
        check_eq("arst_m_data", 32'(m_data), 32'(0));
        check_eq("arst_s_ready", 32'(s_ready), 32'(0));
        check_eq("arst_empty", 32'(empty), 32'(1));
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Randomized traffic; clears only late so the pointers wrap first
        wrap_seen = 1'b0;
        for (int c = 0; c < 3500; c++) begin
            cyc(1);
            if (!s_valid || acc_last) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = 8'($urandom);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            clear   = (c > 2800) && ($urandom_range(0, 199) == 0);
            if (!mem_read) lat = $urandom_range(1, 3);
        end
        clear = 1'b0;
        check_eq("wrap_seen", 32'(wrap_seen), 32'(1));
        drain("final_drain", 4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_buffer_ctrl.md
# sample_buffer_ctrl

Upstream controller for the 256-byte single-port `memory`. It turns that memory into a circular sample FIFO between the sensor front-end and the radio packetiser. Sensor samples arrive on a valid/ready stream and are written to successive addresses. Stored samples are read back in order and presented on a registered valid/ready output stream. The block owns every memory control pin and sequences the memory's two-cycle read protocol.

## Interface
- `DATA_W`, 8: sample and memory data width.
- `ADDR_W`, 8: memory address width.
- `DEPTH`, 256: ring size in entries; must equal 2**ADDR_W.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush of the pointers, the count and the output register.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: input ready.
- `s_data` in DATA_W: input sample.
- `m_valid` out 1: output sample valid.
- `m_ready` in 1: downstream accepts the output sample.
- `m_data` out DATA_W: output sample, registered.
- `count` out ADDR_W+1: number of committed entries, range 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `mem_addr` out ADDR_W: memory address.
- `mem_data` inout DATA_W: memory data bus.
- `mem_write` out 1: memory write enable.
- `mem_read` out 1: memory read enable.
- `mem_data_ready` in 1: memory read-data-ready pulse.

## Operation
- FSM states: IDLE, WRITE, RD_REQ, RD_CAP.
- **Accept (IDLE):** when `s_ready && s_valid`, latch `s_data` into `wdata` and go to WRITE.
- **s_ready:** `s_ready = (state==IDLE) && !full && !clear && (!rd_go || last_op==READ)`.
- **Read-go condition:** `rd_go = !empty && !m_valid`.
- **Read start (IDLE):** when `rd_go` and write is not granted, go to RD_REQ.
- **Arbitration:** when a write and a read are both possible in IDLE, they alternate using the `last_op` flag. Neither direction starves.
- **WRITE:**
  - drive `mem_write=1`, `mem_addr=wr_ptr`, `mem_data=wdata`;
  - at the clock edge, increment `wr_ptr` (mod DEPTH) and `count`;
  - set `last_op=WRITE` and return to IDLE.
- **RD_REQ:** drive `mem_read=1` and `mem_addr=rd_ptr`, then go to RD_CAP.
- **RD_CAP:**
  - hold `mem_read=1` and `mem_addr=rd_ptr`;
  - when `mem_data_ready=1`, capture `mem_data` into `m_data`, set `m_valid`, increment `rd_ptr` (mod DEPTH), decrement `count`, set `last_op=READ`, and return to IDLE;
  - otherwise stay in RD_CAP.
- **Output handshake:** `m_valid` clears on `m_valid && m_ready`. `m_data` is stable while `m_valid && !m_ready`.
- **Bus and strobes:**
  - `mem_data` is driven only in WRITE and is high-Z in every other state;
  - `mem_write` and `mem_read` are never high in the same cycle;
  - both strobes are 0 in IDLE.
- **Pointer wrap:** pointers wrap 255→0 with no special case. `count` is the only full/empty source.
- **clear:** has priority in every state.
  - Resets `wr_ptr`, `rd_ptr`, `count` and `m_valid` to 0, and the state to IDLE.
  - Aborts any in-flight write or read; that entry is lost.
  - Memory contents are not touched.

## Timing
- **Reset values:** state=IDLE; `wr_ptr`, `rd_ptr`, `count`=0; `last_op`=READ; `m_valid`=0; `m_data`=0; `mem_addr`=0; `mem_write`=0; `mem_read`=0; `mem_data`=Z. Hence `empty`=1 and `full`=0.
- **s_ready in reset:** `s_ready`=0 while `rd_n` is low… specifically while `rst_n` is low; it may rise the first cycle after release.
- **Write latency:** accept in cycle N; `mem_write` high in N+1; `count` updated after the N+1 edge; earliest next accept is N+2. Peak write rate is 1 sample per 2 cycles.
- **Read latency:** IDLE decision in cycle N; RD_REQ in N+1; RD_CAP in N+2 (memory pulses `mem_data_ready` and drives `mem_data`); `m_valid` high from N+3.
- **Back-pressure:** a stalled `m_valid` blocks further reads; writes continue until `full`.
- **Full:** when `count==DEPTH`, `s_ready`=0 and the input sample is held by the producer. Nothing is dropped.
- **Empty:** no memory read is issued.

## Structure
- **Shared package `wsn_mem_pkg`:** the FSM state enum, `MEM_DEPTH=256`, `MEM_ADDR_W=8`, `MEM_DATA_W=8`, and the `last_op` encoding. The `memory` block and other memory clients reuse these.
- **Single module:** no sub-module is natural; the pointer/count logic is too small to split.
- **Top-level wiring:** the tri-state is resolved in this block. `mem_data` is wired directly to the `memory` data port.

## Test plan
- **Reset then single sample:** push 0xA5 -> `mem_write` at addr 0 one cycle after accept; `m_valid` with `m_data`=0xA5 appears 3 cycles after the read decision; `count` goes 0→1→0.
- **Fill to full:** hold `m_ready`=0 and stream 0x00..0xFF -> once the first sample sits in the output register, `count` reaches 255 and then 256 with `full`=1 and `s_ready`=0. Draining returns 0x00..0xFF in order.
- **Wrap-around:** write 300 samples while draining continuously -> `wr_ptr` wraps 255→0; output order and values are preserved; `count` never exceeds 256.
- **Simultaneous requests:** `s_valid`=1 constantly while the ring is non-empty and `m_ready`=1 -> grants alternate WRITE, READ, WRITE, READ; `mem_write` and `mem_read` never overlap; `mem_data` is Z outside WRITE.
- **clear mid-read:** assert `clear` during RD_CAP with `count`=5 -> next cycle IDLE, `count`=0, `m_valid`=0, `empty`=1; a following push of 0x3C is read back as 0x3C from addr 0.
- **Async reset mid-write:** drop `rst_n` in WRITE -> `mem_write` falls immediately and all outputs take their reset values without waiting for a clock edge.
